// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - pops words from a FIFO and presents them on a valid/ready stream
// Every output is a flop; next values are computed from the next state.
module fifo_reader #(
  parameter int DATA_WIDTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_fifo_empty,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_F = 2'd1,
    LOAD   = 2'd2,
    VALID  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  rd_en_nxt;
  logic                  valid_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [CNT_WIDTH-1:0]  count_nxt;

  always_comb begin
    state_nxt = state;
    data_nxt  = o_data;
    count_nxt = o_count;
    case (state)
      IDLE: begin
        if (!i_fifo_empty) state_nxt = READ_F;
      end
      READ_F: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid in the cycle after the pop strobe
        data_nxt  = i_data;
        state_nxt = VALID;
      end
      VALID: begin
        if (i_ready) begin
          count_nxt = o_count + CNT_WIDTH'(1);
          data_nxt  = '0;
          state_nxt = i_fifo_empty ? IDLE : READ_F;
        end
      end
      default: begin
        state_nxt = IDLE;
        data_nxt  = '0;
      end
    endcase
    rd_en_nxt = (state_nxt == READ_F);
    valid_nxt = (state_nxt == VALID);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      o_rd_en <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
    end else begin
      state   <= state_nxt;
      o_rd_en <= rd_en_nxt;
      o_valid <= valid_nxt;
      o_data  <= data_nxt;
      o_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        rd_en, rd_en_w;
  logic        valid, valid_w;
  logic [7:0]  data, data_w;
  logic [15:0] count;
  logic [1:0]  count_w;

  logic [7:0]  mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [7:0]  exp_q [$];
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .o_rd_en(rd_en), .i_data(fifo_dout),
    .i_fifo_empty(fifo_empty), .o_valid(valid), .i_ready(ready),
    .o_data(data), .o_count(count)
  );

  fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_w (
    .i_clk(clk), .i_rst(rst), .o_rd_en(rd_en_w), .i_data(fifo_dout),
    .i_fifo_empty(fifo_empty), .o_valid(valid_w), .i_ready(ready),
    .o_data(data_w), .o_count(count_w)
  );

  // behavioural FIFO: read data appears the cycle after the pop
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= 4'd0;
      fifo_dout <= 8'd0;
    end else if (rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !valid && !rd_en && fifo_empty) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL wait_idle: timeout after %0d cycles", budget);
  endtask

  // monitor: compares every completed transfer against the scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("word", 32'(data), 32'(e));
          end
          chk("count_before", 32'(count), 32'(exp_cnt));
          chk("count_w_before", 32'(count_w), 32'(exp_cnt[1:0]));
          exp_cnt = exp_cnt + 16'd1;
        end
        if (!valid) chk("data_zero_idle", 32'(data), 32'h0);
        if (rd_en) chk("rd_en_nonempty", 32'(fifo_empty), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cyc[$];
    logic [1:0] seq[$];
    logic [1:0] prev;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    rst = 1'b0;
    ready = 1'b0;
    wr_ptr = 4'd0;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_count", 32'(count), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single word, 3-cycle latency
    ready = 1'b1;
    push_word(8'hA5);
    @(negedge clk);
    chk("t1_rd_en_c1", 32'(rd_en), 1);
    chk("t1_valid_c1", 32'(valid), 0);
    @(negedge clk);
    chk("t1_rd_en_c2", 32'(rd_en), 0);
    chk("t1_valid_c2", 32'(valid), 0);
    @(negedge clk);
    chk("t1_valid_c3", 32'(valid), 1);
    chk("t1_data_c3", 32'(data), 32'hA5);
    @(negedge clk);
    chk("t1_valid_c4", 32'(valid), 0);
    chk("t1_count", 32'(count), 1);
    chk("t1_rd_en_c4", 32'(rd_en), 0);
    wait_idle(10);

    // backpressure with a second word waiting in the FIFO
    ready = 1'b0;
    push_word(8'hA5);
    repeat (3) @(negedge clk);
    push_word(8'h5A);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(valid), 1);
      chk("bp_data", 32'(data), 32'hA5);
      chk("bp_rd_en", 32'(rd_en), 0);
      if (i < 4) @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_rd_en_after", 32'(rd_en), 1);
    chk("bp_count", 32'(count), 2);
    wait_idle(20);
    chk("bp_count_end", 32'(count), 3);

    // burst of four words
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_en) rd_cyc.push_back(cyc);
    end
    chk("burst_pulses", 32'(rd_cyc.size()), 4);
    for (int i = 1; i < rd_cyc.size(); i++)
      chk("burst_gap", 32'(rd_cyc[i] - rd_cyc[i-1]), 3);
    wait_idle(10);
    chk("burst_count", 32'(count), 7);
    chk("burst_count_w", 32'(count_w), 3);

    // reset while in LOAD
    push_word(8'h77);
    repeat (2) @(negedge clk);
    chk("rl_pre_rd_en", 32'(rd_en), 0);
    chk("rl_pre_valid", 32'(valid), 0);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    wr_ptr = 4'd0;
    #1;
    chk("rl_rd_en", 32'(rd_en), 0);
    chk("rl_valid", 32'(valid), 0);
    chk("rl_data", 32'(data), 0);
    chk("rl_count", 32'(count), 0);
    chk("rl_count_w", 32'(count_w), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rl_after_valid", 32'(valid), 0);
      chk("rl_after_rd_en", 32'(rd_en), 0);
    end

    // empty FIFO for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("empty_rd_en", 32'(rd_en), 0);
      chk("empty_valid", 32'(valid), 0);
    end

    // 2-bit counter wrap over five transfers
    prev = count_w;
    for (int i = 0; i < 5; i++) push_word(8'(8'h10 + i));
    for (int i = 0; i < 40 && seq.size() < 5; i++) begin
      @(negedge clk);
      if (count_w != prev) begin
        seq.push_back(count_w);
        prev = count_w;
      end
    end
    chk("wrap_len", 32'(seq.size()), 5);
    for (int i = 0; i < seq.size(); i++)
      chk("wrap_seq", 32'(seq[i]), 32'(wrap_exp[i]));
    wait_idle(10);
    chk("wrap_count16", 32'(count), 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
